// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared op codes, FSM state encoding and default data width
//               for the multiply/divide unit and the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int unsigned c_data_width = 32;

  localparam logic [7:0] c_op_mult  = 8'd0;
  localparam logic [7:0] c_op_multu = 8'd1;
  localparam logic [7:0] c_op_div   = 8'd2;
  localparam logic [7:0] c_op_divu  = 8'd3;
  localparam logic [7:0] c_op_mthi  = 8'd4;
  localparam logic [7:0] c_op_mtlo  = 8'd5;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_calc = 2'd1,
    st_fix  = 2'd2
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative HI/LO multiply/divide unit (one step per cycle).
//               Define MULT_DIV_DIVIDE_EN to build the divide datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_zero
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int DW = DATA_WIDTH;

  mdu_state_t          r_state;
  mdu_state_t          w_state_nxt;
  logic [CW-1:0]       r_count;
  logic [2*DW-1:0]     r_acc;
  logic [DW-1:0]       r_opnd;
  logic [DW-1:0]       r_hi;
  logic [DW-1:0]       r_lo;
  logic                r_neg_res;
  logic                r_done;
  logic                r_div_zero;

  logic [7:0]          w_opc;
  logic                w_is_mul;
  logic                w_is_dvd;
  logic                w_signed_op;
  logic                w_s1;
  logic                w_s2;
  logic [DW-1:0]       w_mag1;
  logic [DW-1:0]       w_mag2;
  logic                w_accept;
  logic [DW-1:0]       w_addend;
  logic [DW:0]         w_mul_sum;
  logic [2*DW-1:0]     w_mul_step;
  logic [2*DW-1:0]     w_step;
  logic [2*DW-1:0]     w_prod;

  assign w_opc    = 8'(op);
  assign w_is_mul = (w_opc == c_op_mult) || (w_opc == c_op_multu);

`ifdef MULT_DIV_DIVIDE_EN
  logic                r_is_div;
  logic                r_neg_rem;
  logic                r_dz;
  logic [DW:0]         w_shift;
  logic [DW:0]         w_diff;
  logic [2*DW-1:0]     w_div_step;
  logic [DW-1:0]       w_quo;
  logic [DW-1:0]       w_rem;
  logic [DW-1:0]       w_lo_div;
  logic [DW-1:0]       w_hi_div;

  assign w_is_dvd    = (w_opc == c_op_div) || (w_opc == c_op_divu);
  assign w_signed_op = (w_opc == c_op_mult) || (w_opc == c_op_div);

  // Restoring step: the partial remainder always stays below the divisor,
  // so bit DW of the difference is a clean borrow flag.
  assign w_shift    = r_acc[2*DW-1:DW-1];
  assign w_diff     = w_shift - {1'b0, r_opnd};
  assign w_div_step = w_diff[DW] ? {w_shift[DW-1:0], r_acc[DW-2:0], 1'b0}
                                 : {w_diff[DW-1:0], r_acc[DW-2:0], 1'b1};
  assign w_step     = r_is_div ? w_div_step : w_mul_step;

  assign w_quo    = r_acc[DW-1:0];
  assign w_rem    = r_acc[2*DW-1:DW];
  assign w_lo_div = r_dz ? '1 : (r_neg_res ? -w_quo : w_quo);
  assign w_hi_div = r_neg_rem ? -w_rem : w_rem;
`else
  assign w_is_dvd    = 1'b0;
  assign w_signed_op = (w_opc == c_op_mult);
  assign w_step      = w_mul_step;
`endif

  assign w_s1     = w_signed_op & operand1[DW-1];
  assign w_s2     = w_signed_op & operand2[DW-1];
  assign w_mag1   = w_s1 ? -operand1 : operand1;
  assign w_mag2   = w_s2 ? -operand2 : operand2;
  assign w_accept = (r_state == st_idle) && start && (w_is_mul || w_is_dvd);

  // Shift-add: upper half accumulates, lower half shifts the multiplier out.
  assign w_addend   = r_acc[0] ? r_opnd : '0;
  assign w_mul_sum  = {1'b0, r_acc[2*DW-1:DW]} + {1'b0, w_addend};
  assign w_mul_step = {w_mul_sum, r_acc[DW-1:1]};
  assign w_prod     = r_neg_res ? -r_acc : r_acc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      st_idle: if (w_accept) w_state_nxt = st_calc;
      st_calc: if (r_count == '0) w_state_nxt = st_fix;
      st_fix:  w_state_nxt = st_idle;
      default: w_state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= st_idle;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_neg_res  <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef MULT_DIV_DIVIDE_EN
      r_is_div   <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dz       <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        st_idle: begin
          if (w_accept) begin
            r_count   <= CW'(DW);
            r_neg_res <= w_s1 ^ w_s2;
            // Multiply: r_opnd = multiplicand; divide: r_opnd = divisor.
            r_opnd    <= w_is_dvd ? w_mag2 : w_mag1;
            r_acc     <= {{DW{1'b0}}, (w_is_dvd ? w_mag1 : w_mag2)};
`ifdef MULT_DIV_DIVIDE_EN
            r_is_div  <= w_is_dvd;
            r_neg_rem <= w_s1;
            r_dz      <= (operand2 == '0);
`endif
          end else if (start && (w_opc == c_op_mthi)) begin
            r_hi <= operand1;
          end else if (start && (w_opc == c_op_mtlo)) begin
            r_lo <= operand1;
          end
        end
        st_calc: begin
          if (r_count != '0) begin
            r_acc   <= w_step;
            r_count <= r_count - CW'(1);
          end
        end
        st_fix: begin
          r_done <= 1'b1;
`ifdef MULT_DIV_DIVIDE_EN
          if (r_is_div) begin
            r_hi       <= w_hi_div;
            r_lo       <= w_lo_div;
            r_div_zero <= r_dz;
          end else begin
            r_hi <= w_prod[2*DW-1:DW];
            r_lo <= w_prod[DW-1:0];
          end
`else
          r_hi <= w_prod[2*DW-1:DW];
          r_lo <= w_prod[DW-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != st_idle);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic
//               reference model. Honours MULT_DIV_DIVIDE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  localparam int DW = 32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {div_zero, hi, lo} straight from the arithmetic definition.
  function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    logic [31:0] q;
    logic [31:0] r;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, 64'(sp)};
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return {1'b0, up};
      end
      3'd2: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {1'b0, r, q};
      end
      3'd3: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: return 65'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issues one iterative op and observes timing; all comparisons happen in callers.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic dz,
                        output int lat, output int bcnt, output logic done_nxt, output logic dz_nxt);
    @(negedge clk);
    op = o; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand1 = $urandom; operand2 = $urandom; op = 3'($urandom);
    lat = -1; bcnt = 0; h = '0; l = '0; dz = 1'b0; done_nxt = 1'b1; dz_nxt = 1'b1;
    if (busy) bcnt++;
    for (int k = 1; k <= DW + 10 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        lat = k; h = hi; l = lo; dz = div_zero;
      end
    end
    if (lat >= 0) begin
      @(posedge clk); #1;
      done_nxt = done; dz_nxt = div_zero;
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] h, l;
    logic        dz, dn, dzn;
    int          lat, bcnt;
    logic [64:0] exp;
    exp = model(o, a, b);
    run_op(o, a, b, h, l, dz, lat, bcnt, dn, dzn);
    n_tests++;
    if (lat !== DW + 2) begin n_fail++; $display("FAIL %s latency got=%0d want=%0d", name, lat, DW + 2); end
    n_tests++;
    if (bcnt !== DW + 2) begin n_fail++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, bcnt, DW + 2); end
    n_tests++;
    if (h !== exp[63:32]) begin n_fail++; $display("FAIL %s hi op=%0d a=%h b=%h got=%h want=%h", name, o, a, b, h, exp[63:32]); end
    n_tests++;
    if (l !== exp[31:0]) begin n_fail++; $display("FAIL %s lo op=%0d a=%h b=%h got=%h want=%h", name, o, a, b, l, exp[31:0]); end
    n_tests++;
    if (dz !== exp[64]) begin n_fail++; $display("FAIL %s div_zero got=%b want=%b", name, dz, exp[64]); end
    n_tests++;
    if ({dn, dzn} !== 2'b00) begin n_fail++; $display("FAIL %s pulse_width done/dz after got=%b%b want=00", name, dn, dzn); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b want=000", {busy, done, div_zero}); end
    n_tests++;
    if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo got=%h want=0", {hi, lo}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_move();
    logic [31:0] v1, v2;
    v1 = $urandom; v2 = $urandom;
    @(negedge clk); op = 3'd4; operand1 = v1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_tests++;
    if (hi !== v1 || busy !== 1'b0) begin n_fail++; $display("FAIL mthi got hi=%h busy=%b want hi=%h busy=0", hi, busy, v1); end
    @(negedge clk); op = 3'd5; operand1 = v2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_tests++;
    if (lo !== v2 || hi !== v1 || busy !== 1'b0) begin n_fail++; $display("FAIL mtlo got hi=%h lo=%h busy=%b want %h %h 0", hi, lo, busy, v1, v2); end
    repeat (3) begin
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL move_no_done got=%b want=0", done); end
    end
  endtask

  task automatic test_undefined();
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    for (int c = 6; c <= 7; c++) begin
      @(negedge clk); op = 3'(c); operand1 = $urandom; operand2 = $urandom; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n_tests++;
      if ({busy, hi, lo} !== {1'b0, h0, l0}) begin n_fail++; $display("FAIL undefined_op%0d got busy=%b hi=%h lo=%h want 0 %h %h", c, busy, hi, lo, h0, l0); end
    end
  endtask

  task automatic test_mult();
    check_op("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5);
    check_op("multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'd2);
    check_op("mult_minxmin", 3'd0, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 10; i++) check_op("mult_rand", 3'($urandom_range(0, 1)), pick(), pick());
  endtask

`ifdef MULT_DIV_DIVIDE_EN
  task automatic test_divide();
    check_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("divu_100_0", 3'd3, 32'd100, 32'd0);
    check_op("div_neg_0", 3'd2, 32'hFFFF_FF00, 32'd0);
    for (int i = 0; i < 12; i++) check_op("div_rand", 3'($urandom_range(2, 3)), pick(), pick());
  endtask
`else
  task automatic test_divide();
    logic [31:0] h0, l0;
    int          seen;
    h0 = hi; l0 = lo;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk); op = 3'(c); operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL div_disabled_busy op=%0d got=%b want=0", c, busy); end
      seen = 0;
      repeat (DW + 4) begin
        @(posedge clk); #1;
        if (done || div_zero) seen++;
      end
      n_tests++;
      if (seen !== 0 || hi !== h0 || lo !== l0) begin n_fail++; $display("FAIL div_disabled_effect op=%0d pulses=%0d hi=%h lo=%h want 0 %h %h", c, seen, hi, lo, h0, l0); end
    end
  endtask
`endif

  task automatic test_random_mix();
    logic [2:0] o;
    for (int i = 0; i < 12; i++) begin
`ifdef MULT_DIV_DIVIDE_EN
      o = 3'($urandom_range(0, 3));
`else
      o = 3'($urandom_range(0, 1));
`endif
      check_op("mix_rand", o, $urandom, pick());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, h, l;
    logic [64:0] exp;
    int          lat;
    a = $urandom; b = $urandom;
    exp = model(3'd0, a, b);
    @(negedge clk); op = 3'd0; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); op = 3'd1; operand1 = ~a; operand2 = b ^ 32'h5A5A_5A5A; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = -1; h = '0; l = '0;
    for (int k = 6; k <= DW + 12 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; h = hi; l = lo; end
    end
    n_tests++;
    if (lat !== DW + 2) begin n_fail++; $display("FAIL busy_start_latency got=%0d want=%0d", lat, DW + 2); end
    n_tests++;
    if ({h, l} !== exp[63:0]) begin n_fail++; $display("FAIL busy_start_result got=%h want=%h", {h, l}, exp[63:0]); end
    // A start issued together with the previous done is a fresh, legal request.
    check_op("b2b_next", 3'd1, 32'h0001_0000, 32'h0001_0000);
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk); op = 3'd4; operand1 = 32'hDEAD_0001; start = 1'b1;
    @(negedge clk); op = 3'd5; operand1 = 32'hBEEF_0002;
    @(negedge clk);
`ifdef MULT_DIV_DIVIDE_EN
    op = 3'd2;
`else
    op = 3'd0;
`endif
    operand1 = 32'd1000; operand2 = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got=%b want=000", {busy, done, div_zero}); end
    n_tests++;
    if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL abort_hilo got=%h want=0", {hi, lo}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (DW + 4) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d want=0", seen); end
    @(negedge clk); op = 3'd5; operand1 = 32'h0000_1234; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_tests++;
    if ({hi, lo} !== {32'd0, 32'h0000_1234}) begin n_fail++; $display("FAIL abort_mtlo got=%h want=%h", {hi, lo}, {32'd0, 32'h0000_1234}); end
    check_op("after_abort", 3'd0, 32'hFFFF_FFFD, 32'd5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_move();
    test_undefined();
    test_mult();
    test_divide();
    test_random_mix();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/HI/LO width.
REQ-002 SHALL have parameter OP_WIDTH, default 3, op select width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  request strobe, sampled when busy=0.
REQ-006 SHALL have port op  input  OP_WIDTH  MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; others no-op.
REQ-007 SHALL have port operand1  input  DATA_WIDTH  multiplicand/dividend/move source (same rs bus as ALU operand1).
REQ-008 SHALL have port operand2  input  DATA_WIDTH  multiplier/divisor (same rt bus as ALU operand2).
REQ-009 SHALL have port busy  output  1  iterative operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, HI/LO updated.
REQ-011 SHALL have port hi  output  DATA_WIDTH  HI register (product upper half / remainder).
REQ-012 SHALL have port lo  output  DATA_WIDTH  LO register (product lower half / quotient).
REQ-013 SHALL have port div_zero  output  1  pulses with done when divisor was zero.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX; reset state IDLE.
REQ-015 IDLE + start + op in {0..3}: latch operands as magnitudes (signed ops: absolute value, remember result/remainder signs), load counter=DATA_WIDTH, go CALC, busy=1 next cycle.
REQ-016 CALC SHALL perform one shift-add (multiply) or restoring subtract-shift (divide) step per cycle, decrement counter, go FIX when counter reaches 0.
REQ-017 FIX SHALL apply sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign), write HI/LO, pulse done, return IDLE.
REQ-018 Latency: start edge N -> done high and HI/LO valid after edge N+DATA_WIDTH+2; busy high from edge N through edge N+DATA_WIDTH+1.
REQ-019 start while busy=1 SHALL be ignored; operands need only be valid at the accepting edge.
REQ-020 MTHI/MTLO in IDLE SHALL write operand1 to HI/LO at the start edge; no busy, no done.
REQ-021 Undefined op codes SHALL be ignored, no state change.
REQ-022 Divide by zero: LO=all ones, HI=operand1, div_zero=1 with done, same latency.
REQ-023 Signed DIV of most-negative by -1: LO=most-negative, HI=0, no flag.
REQ-024 MULT/MULTU SHALL produce full 2*DATA_WIDTH product, HI upper, LO lower.
REQ-025 hi/lo SHALL hold value between operations; done and div_zero low except the FIX-exit pulse.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0.
REQ-027 rst mid-operation SHALL abort with no done pulse; first start after deassertion SHALL behave as from fresh reset.

Configuration
REQ-028 Macro MULT_DIV_DIVIDE_EN defined: DIV/DIVU implemented as above.
REQ-029 Macro undefined: divide datapath absent; DIV/DIVU treated as undefined ops (REQ-021), div_zero tied 0.

Structure
REQ-030 Op codes, state encoding and DATA_WIDTH default SHALL live in shared package mips_pkg, also used by the control unit.
REQ-031 SHALL contain no sub-module; sign handling and iteration step inline (single always_ff FSM + datapath).

Verification
REQ-032 MULT operand1=0xFFFFFFFD(-3), operand2=5 -> done after 34 cycles, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 MULTU 0xFFFFFFFF x 2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064, div_zero pulse 1 cycle with done.
REQ-036 start MULT, second start at cycle 5 with different operands -> ignored, first result delivered unchanged.
REQ-037 rst asserted at cycle 10 of DIV -> busy=0, hi=lo=0 immediately, no done; MTLO 0x1234 after release -> lo=0x1234 next edge.
